strip_mine_seq: RTL and testbench

STRIP_MINE_SEQ -- requirements
Module: strip_mine_seq

---
 rtl/vec_cfg_pkg.sv | 15 +
 rtl/vlmax_calc.sv | 21 ++
 rtl/strip_mine_seq.sv | 100 ++++++++++
 tb/tb_strip_mine_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_cfg_pkg.sv
// vec_cfg_pkg: shared vector-config encodings, sequencer state type and limits
package vec_cfg_pkg;
  localparam logic [2:0] SEW_8    = 3'b000;
  localparam logic [2:0] SEW_16   = 3'b001;
  localparam logic [2:0] SEW_32   = 3'b010;
  localparam logic [2:0] SEW_64   = 3'b011;
  localparam logic [2:0] SEW_128  = 3'b100;
  localparam logic [2:0] LMUL_1   = 3'b000;
  localparam logic [2:0] LMUL_2   = 3'b001;
  localparam logic [2:0] LMUL_4   = 3'b010;
  localparam logic [2:0] LMUL_8   = 3'b011;
  localparam logic [2:0] LMUL_16  = 3'b100;
  localparam logic [8:0] AVL_MAX  = 9'd256;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/vlmax_calc.sv
// vlmax_calc: elements per vector register group for a sew/lmul pair, saturated to AVL_MAX
module vlmax_calc
  import vec_cfg_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [2:0] sew,
  input  logic [2:0] lmul,
  output logic [8:0] vlmax,
  output logic       legal
);
  logic [15:0] per_reg;
  logic [15:0] raw;
  // Wide intermediate so the group size cannot wrap before saturation
  always_comb begin
    per_reg = 16'(VLEN) >> (4'(sew) + 4'd3);
    raw     = per_reg << lmul;
    vlmax   = (raw > 16'(AVL_MAX)) ? AVL_MAX : raw[8:0];
    legal   = (sew <= SEW_128) && (lmul <= LMUL_16);
  end
endmodule

// File: rtl/strip_mine_seq.sv
// strip_mine_seq: splits an AVL-element job into VLMAX-sized strip descriptors
module strip_mine_seq
  import vec_cfg_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sew,
  input  logic [2:0] req_lmul,
  input  logic [8:0] req_avl,
  output logic       strip_valid,
  input  logic       strip_ready,
  output logic [8:0] strip_vl,
  output logic [8:0] strip_offset,
  output logic       strip_last,
  input  logic       flush,
  output logic       done,
  output logic       err
);
  state_t     state;
  logic [2:0] sew_q;
  logic [2:0] lmul_q;
  logic [8:0] remaining;
  logic [2:0] cfg_sew;
  logic [2:0] cfg_lmul;
  logic [8:0] vlmax;
  logic       cfg_legal;
  logic [8:0] rem_base;
  logic [8:0] next_vl;
  logic       req_ok;
  assign req_ready = (state == IDLE);
  // In IDLE the first strip is sized from the incoming request; afterwards from the latched config
  always_comb begin
    cfg_sew  = (state == IDLE) ? req_sew : sew_q;
    cfg_lmul = (state == IDLE) ? req_lmul : lmul_q;
    rem_base = (state == IDLE) ? req_avl : remaining - strip_vl;
    next_vl  = (rem_base < vlmax) ? rem_base : vlmax;
    req_ok   = cfg_legal && (req_avl <= AVL_MAX);
  end
  vlmax_calc #(.VLEN(VLEN)) u_vlmax (
    .sew   (cfg_sew),
    .lmul  (cfg_lmul),
    .vlmax (vlmax),
    .legal (cfg_legal)
  );
  // Sequencer: accept/reject, emit registered strips, pulse done after FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sew_q        <= SEW_8;
      lmul_q       <= LMUL_1;
      remaining    <= '0;
      strip_valid  <= 1'b0;
      strip_vl     <= '0;
      strip_offset <= '0;
      strip_last   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        strip_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            if (!req_ok) err <= 1'b1;
            else begin
              sew_q        <= req_sew;
              lmul_q       <= req_lmul;
              remaining    <= req_avl;
              strip_offset <= '0;
              strip_vl     <= next_vl;
              strip_last   <= (req_avl <= vlmax);
              strip_valid  <= (req_avl != '0);
              state        <= (req_avl == '0) ? FIN : RUN;
            end
          end
          RUN: if (strip_valid && strip_ready) begin
            remaining    <= rem_base;
            strip_offset <= strip_offset + strip_vl;
            strip_vl     <= next_vl;
            strip_last   <= (rem_base <= vlmax);
            strip_valid  <= !strip_last;
            state        <= strip_last ? FIN : RUN;
          end
          FIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_strip_mine_seq.sv
// tb_strip_mine_seq: table-driven first-strip vectors plus directed multi-cycle sequences
module tb_strip_mine_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_sew = '0;
  logic [2:0] req_lmul = '0;
  logic [8:0] req_avl = '0;
  logic       strip_valid;
  logic       strip_ready = 1'b0;
  logic [8:0] strip_vl;
  logic [8:0] strip_offset;
  logic       strip_last;
  logic       flush = 1'b0;
  logic       done;
  logic       err;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] sew;
    logic [2:0] lmul;
    logic [8:0] avl;
    logic       e_err;
    logic [8:0] e_vl;
    logic       e_last;
  } vec_t;
  vec_t tbl [13];

  strip_mine_seq #(.VLEN(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sew      (req_sew),
    .req_lmul     (req_lmul),
    .req_avl      (req_avl),
    .strip_valid  (strip_valid),
    .strip_ready  (strip_ready),
    .strip_vl     (strip_vl),
    .strip_offset (strip_offset),
    .strip_last   (strip_last),
    .flush        (flush),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_strip(input string name, input logic [8:0] vl, input logic [8:0] off, input logic last);
    chk({name, ".valid"}, 32'(strip_valid), 32'd1);
    chk({name, ".vl"}, 32'(strip_vl), 32'(vl));
    chk({name, ".off"}, 32'(strip_offset), 32'(off));
    chk({name, ".last"}, 32'(strip_last), 32'(last));
  endtask

  task automatic issue(input logic [2:0] s, input logic [2:0] l, input logic [8:0] a);
    req_valid = 1'b1;
    req_sew   = s;
    req_lmul  = l;
    req_avl   = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic tail_done(input string name);
    chk({name, ".fin_valid"}, 32'(strip_valid), 32'd0);
    chk({name, ".fin_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    chk({name, ".done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 3'd0, 9'd20,  1'b0, 9'd16,  1'b0};
    tbl[1]  = '{3'd0, 3'd4, 9'd256, 1'b0, 9'd256, 1'b1};
    tbl[2]  = '{3'd1, 3'd1, 9'd16,  1'b0, 9'd16,  1'b1};
    tbl[3]  = '{3'd2, 3'd1, 9'd20,  1'b0, 9'd8,   1'b0};
    tbl[4]  = '{3'd3, 3'd2, 9'd5,   1'b0, 9'd5,   1'b1};
    tbl[5]  = '{3'd4, 3'd3, 9'd200, 1'b0, 9'd8,   1'b0};
    tbl[6]  = '{3'd4, 3'd0, 9'd1,   1'b0, 9'd1,   1'b1};
    tbl[7]  = '{3'd2, 3'd4, 9'd100, 1'b0, 9'd64,  1'b0};
    tbl[8]  = '{3'd0, 3'd3, 9'd128, 1'b0, 9'd128, 1'b1};
    tbl[9]  = '{3'd5, 3'd0, 9'd5,   1'b1, 9'd0,   1'b0};
    tbl[10] = '{3'd0, 3'd5, 9'd5,   1'b1, 9'd0,   1'b0};
    tbl[11] = '{3'd0, 3'd0, 9'd257, 1'b1, 9'd0,   1'b0};
    tbl[12] = '{3'd7, 3'd7, 9'd511, 1'b1, 9'd0,   1'b0};

    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.valid", 32'(strip_valid), 32'd0);
    chk("rst.vl", 32'(strip_vl), 32'd0);
    chk("rst.off", 32'(strip_offset), 32'd0);
    chk("rst.last", 32'(strip_last), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    strip_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].sew, tbl[i].lmul, tbl[i].avl);
      chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].e_err));
      if (tbl[i].e_err) begin
        chk($sformatf("tbl%0d.valid", i), 32'(strip_valid), 32'd0);
        chk($sformatf("tbl%0d.ready", i), 32'(req_ready), 32'd1);
        @(negedge clk);
        chk($sformatf("tbl%0d.err_low", i), 32'(err), 32'd0);
        chk($sformatf("tbl%0d.done", i), 32'(done), 32'd0);
      end else begin
        chk_strip($sformatf("tbl%0d", i), tbl[i].e_vl, 9'd0, tbl[i].e_last);
        strip_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        strip_ready = 1'b1;
        chk($sformatf("tbl%0d.flush_valid", i), 32'(strip_valid), 32'd0);
        chk($sformatf("tbl%0d.flush_ready", i), 32'(req_ready), 32'd1);
      end
    end

    issue(3'd2, 3'd1, 9'd20);
    chk_strip("b2b.s0", 9'd8, 9'd0, 1'b0);
    @(negedge clk);
    chk_strip("b2b.s1", 9'd8, 9'd8, 1'b0);
    @(negedge clk);
    chk_strip("b2b.s2", 9'd4, 9'd16, 1'b1);
    @(negedge clk);
    tail_done("b2b");

    issue(3'd2, 3'd1, 9'd20);
    chk_strip("stall.s0", 9'd8, 9'd0, 1'b0);
    @(negedge clk);
    strip_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_strip($sformatf("stall.hold%0d", k), 9'd8, 9'd8, 1'b0);
      @(negedge clk);
    end
    strip_ready = 1'b1;
    chk_strip("stall.s1", 9'd8, 9'd8, 1'b0);
    @(negedge clk);
    chk_strip("stall.s2", 9'd4, 9'd16, 1'b1);
    @(negedge clk);
    tail_done("stall");

    issue(3'd0, 3'd0, 9'd0);
    chk("avl0.ready", 32'(req_ready), 32'd0);
    tail_done("avl0");

    issue(3'd4, 3'd0, 9'd256);
    for (int k = 0; k < 256; k++) begin
      chk_strip($sformatf("sew128.s%0d", k), 9'd1, 9'(k), k == 255);
      @(negedge clk);
    end
    tail_done("sew128");

    issue(3'd2, 3'd1, 9'd20);
    @(negedge clk);
    chk_strip("flush.s1", 9'd8, 9'd8, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.valid", 32'(strip_valid), 32'd0);
    chk("flush.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("flush.done", 32'(done), 32'd0);
    @(negedge clk);
    chk("flush.done2", 32'(done), 32'd0);
    flush = 1'b1;
    issue(3'd0, 3'd0, 9'd20);
    flush = 1'b0;
    chk("flush_idle.valid", 32'(strip_valid), 32'd0);
    chk("flush_idle.ready", 32'(req_ready), 32'd1);
    issue(3'd0, 3'd0, 9'd20);
    chk_strip("flush.new0", 9'd16, 9'd0, 1'b0);
    @(negedge clk);
    chk_strip("flush.new1", 9'd4, 9'd16, 1'b1);
    @(negedge clk);
    tail_done("flush.new");

    issue(3'd2, 3'd1, 9'd20);
    @(negedge clk);
    chk_strip("rstmid.s1", 9'd8, 9'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.valid", 32'(strip_valid), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    chk("rstmid.vl", 32'(strip_vl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.done", 32'(done), 32'd0);
    issue(3'd1, 3'd0, 9'd10);
    chk_strip("rstmid.new0", 9'd8, 9'd0, 1'b0);
    @(negedge clk);
    chk_strip("rstmid.new1", 9'd2, 9'd8, 1'b1);
    @(negedge clk);
    tail_done("rstmid.new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
